dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port 32-word data memory. It shares the memory between the CPU load/store path (requester 0) and the memory loader/debug port (requester 1), which initialises and inspects arrays such as the sort workload. It serialises accesses through a fixed 4-state FSM with round-robin or fixed priority, drives the memory's command port, and returns read data with a one-cycle acknowledge.

Parameters:
DATA_W, 32, data word width
ADDR_W, 5, word address width (32 words)
PRIO_FIXED, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req0  in  1  requester 0 access request, level
we0  in  1  requester 0 write enable (1 = write, 0 = read)
addr0  in  ADDR_W  requester 0 word address
wdata0  in  DATA_W  requester 0 write data
ack0  out  1  requester 0 transaction complete, one-cycle pulse
rdata0  out  DATA_W  requester 0 read data, valid while ack0=1
req1, we1, addr1, wdata1, ack1, rdata1  as above, for requester 1
mem_en  out  1  memory command valid
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en (synchronous read)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate): state=IDLE. ack0/1=0, rdata0/1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0. Round-robin pointer last_gnt=1, so requester 0 wins the first tie.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM, one state per cycle except IDLE:
  - IDLE: when req0 or req1 is sampled high, select a winner and latch we/addr/wdata/id. Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: mem_en=1; mem_we, mem_addr, mem_wdata = latched command. The memory acts on the edge that ends ISSUE. Go to CAPT.
  - CAPT: mem_en=0, mem_we=0. If the transaction is a read, latch mem_rdata into the winner's rdata register. Go to ACK.
  - ACK: winner's ack=1 for exactly this cycle. rdataN is valid if the transaction was a read. Go to IDLE.
- Latency: request sampled at edge E0 (IDLE). mem_en is high in cycle 1, and ackN is high in cycle 3 after E0. Peak throughput is one transaction per 4 cycles.
- Selection:
  - Only one request high: that requester wins.
  - Both high with PRIO_FIXED=0: the requester not equal to last_gnt wins. last_gnt updates on entry to ISSUE.
  - Both high with PRIO_FIXED=1: requester 0 wins.
- Requester protocol:
  - Hold req and the command stable until ack. The command is latched in IDLE, so later input changes are ignored.
  - To stop, drop req in the cycle after ack. If req is still high in the cycle after ack, that is a new transaction.
- Dropping req mid-transaction does not abort it; the ack is still issued.
- Writes: rdataN keeps its previous value; ackN still pulses.
- Only one ack is high in any cycle. ack is never asserted outside ACK.
- The losing requester's request is held off, not lost. It is served in the next IDLE if it is still high, so starvation is bounded to one transaction under round-robin.
- Reset mid-operation: the transaction is abandoned and no ack is issued. If reset is asserted before the edge ending ISSUE, the write does not reach memory.
- All address values are legal. Address width matches depth, so there is no wrap or out-of-range case.

Test Plan:
- Reset asserted with both reqs high -> all outputs 0 immediately; after release, first tie goes to requester 0.
- mem[2]=35; req0 read addr 2 sampled at E0 -> mem_en=1, mem_addr=2 in cycle 1; ack0=1, rdata0=35 in cycle 3; ack1 stays 0.
- Both requesters request in the same cycle: r0 writes 18 to addr 4, r1 reads addr 4 -> ack0 first; ack1 follows 4 cycles later with rdata1=18.
- Both reqs held high for 4 transactions -> acks alternate 0,1,0,1; with PRIO_FIXED=1 -> 0,0,0,0 and ack1 never pulses.
- r1 write addr 0 = 76, reset pulsed during ISSUE before the edge -> mem[0] unchanged, no ack1, busy=0, FSM in IDLE.
- r0 write addr 3 = 2, req kept high after ack with a read of addr 3 -> second ack0 4 cycles after the first, rdata0=2, rdata0 unchanged by the write.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-requester arbiter/sequencer for the single-port data memory.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int PRIO_FIXED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t              state_q;
    logic                last_gnt_q;
    logic                id_q;
    logic                we_q;
    logic                ack0_q;
    logic                ack1_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                busy_q;
    logic                gnt_d;

    // gnt_d = 1 selects requester 1; ties go away from the last winner
    always_comb begin
        gnt_d = req1;
        if (req0 && req1) begin
            gnt_d = (PRIO_FIXED != 0) ? 1'b0 : ~last_gnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_gnt_q  <= 1'b1;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        state_q     <= S_ISSUE;
                        id_q        <= gnt_d;
                        last_gnt_q  <= gnt_d;
                        we_q        <= gnt_d ? we1 : we0;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= gnt_d ? we1 : we0;
                        mem_addr_q  <= gnt_d ? addr1 : addr0;
                        mem_wdata_q <= gnt_d ? wdata1 : wdata0;
                        busy_q      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= S_CAPT;
                end
                S_CAPT: begin
                    // Synchronous-read data is valid during this cycle only
                    if (!we_q) begin
                        if (id_q) rdata1_q <= mem_rdata;
                        else      rdata0_q <= mem_rdata;
                    end
                    ack0_q  <= ~id_q;
                    ack1_q  <= id_q;
                    state_q <= S_ACK;
                end
                S_ACK: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed bench for dmem_arbiter (round-robin and fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [4:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, mem_en, mem_we, busy;
    logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [4:0]  mem_addr;
    logic        f_ack0, f_ack1, f_mem_en, f_mem_we, f_busy;
    logic [31:0] f_rdata0, f_rdata1, f_mem_wdata;
    logic [4:0]  f_mem_addr;
    logic [31:0] c_zero;

    logic        bd_we;
    logic [4:0]  bd_addr;
    logic [31:0] bd_data;
    logic [31:0] mem [32];

    int checks;
    int errors;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(5), .PRIO_FIXED(0)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(5), .PRIO_FIXED(1)) dut_fixed (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(f_ack0), .rdata0(f_rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(f_ack1), .rdata1(f_rdata1),
        .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_rdata(c_zero), .busy(f_busy)
    );

    assign c_zero = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous-read memory with a backdoor load port
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd7; wdata0 = 32'd0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd9; wdata1 = 32'd0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b exp 0", mem_en); end
        checks++; if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL rst_acks got %b exp 00", {ack0, ack1}); end
        checks++; if (rdata0 !== 32'd0 || rdata1 !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", rdata0, rdata1); end
        bd_we = 1'b1; bd_data = 32'd0;
        for (int i = 0; i < 32; i++) begin
            bd_addr = 5'(i);
            tick;
        end
        bd_we = 1'b0;
        rst = 1'b0;
        tick;
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL pre_async_mem_en got %b exp 1", mem_en); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({mem_en, busy, mem_addr} !== 7'd0) begin errors++; $display("FAIL async_rst got en=%b busy=%b addr=%0d exp 0", mem_en, busy, mem_addr); end
        tick;
        rst = 1'b0;
        tick;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 5'd7) begin errors++; $display("FAIL first_tie got en=%b addr=%0d exp 1/7", mem_en, mem_addr); end
        tick; tick;
        checks++; if ({ack0, ack1} !== 2'b10) begin errors++; $display("FAIL first_tie_ack got %b exp 10", {ack0, ack1}); end
        req0 = 1'b0; req1 = 1'b0;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_read;
        bd_we = 1'b1; bd_addr = 5'd2; bd_data = 32'd35;
        tick;
        bd_we = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd2;
        tick;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd2) begin errors++; $display("FAIL rd_issue got en=%b we=%b addr=%0d exp 1/0/2", mem_en, mem_we, mem_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy got %b exp 1", busy); end
        tick;
        checks++; if (mem_en !== 1'b0 || ack0 !== 1'b0) begin errors++; $display("FAIL rd_capt got en=%b ack0=%b exp 0/0", mem_en, ack0); end
        tick;
        checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin errors++; $display("FAIL rd_ack got %b%b exp 10", ack0, ack1); end
        checks++; if (rdata0 !== 32'd35) begin errors++; $display("FAIL rd_data got %0d exp 35", rdata0); end
        req0 = 1'b0;
        tick;
        checks++; if (ack0 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_end got ack0=%b busy=%b exp 0/0", ack0, busy); end
    endtask

    task automatic test_contention;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd4; wdata0 = 32'd18;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd4;
        tick;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 5'd4 || mem_wdata !== 32'd18) begin errors++; $display("FAIL ct_wr got we=%b addr=%0d wd=%0d exp 1/4/18", mem_we, mem_addr, mem_wdata); end
        tick; tick;
        checks++; if ({ack0, ack1} !== 2'b10) begin errors++; $display("FAIL ct_ack0 got %b exp 10", {ack0, ack1}); end
        req0 = 1'b0;
        tick;
        checks++; if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL ct_gap got %b exp 00", {ack0, ack1}); end
        tick;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd4) begin errors++; $display("FAIL ct_rd got en=%b we=%b addr=%0d exp 1/0/4", mem_en, mem_we, mem_addr); end
        tick; tick;
        checks++; if ({ack0, ack1} !== 2'b01) begin errors++; $display("FAIL ct_ack1 got %b exp 01", {ack0, ack1}); end
        checks++; if (rdata1 !== 32'd18) begin errors++; $display("FAIL ct_rdata1 got %0d exp 18", rdata1); end
        req1 = 1'b0;
        tick;
    endtask

    task automatic test_round_robin;
        int exp_rr [4] = '{0, 1, 0, 1};
        int seq [4] = '{-1, -1, -1, -1};
        int fseq [4] = '{-1, -1, -1, -1};
        int n = 0;
        int nf = 0;
        int f1 = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd2;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd4;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            tick;
            checks++; if (ack0 && ack1) begin errors++; $display("FAIL rr_dual_ack got 11 exp one-hot"); end
            if (f_ack1) f1++;
            if (f_ack0 || f_ack1) begin
                if (nf < 4) fseq[nf] = f_ack1 ? 1 : 0;
                nf++;
            end
            if (ack0 || ack1) begin
                seq[n] = ack1 ? 1 : 0;
                n++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (n !== 4) begin errors++; $display("FAIL rr_count got %0d exp 4", n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (seq[i] !== exp_rr[i]) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, seq[i], exp_rr[i]); end
            checks++; if (fseq[i] !== 0) begin errors++; $display("FAIL fixed_order[%0d] got %0d exp 0", i, fseq[i]); end
        end
        checks++; if (f1 !== 0) begin errors++; $display("FAIL fixed_ack1 got %0d pulses exp 0", f1); end
        checks++; if (rdata0 !== 32'd35 || rdata1 !== 32'd18) begin errors++; $display("FAIL rr_rdata got %0d/%0d exp 35/18", rdata0, rdata1); end
        tick;
    endtask

    task automatic test_back_to_back;
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd3; wdata0 = 32'd2;
        tick;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 5'd3 || mem_wdata !== 32'd2) begin errors++; $display("FAIL b2b_wr got we=%b addr=%0d wd=%0d exp 1/3/2", mem_we, mem_addr, mem_wdata); end
        tick; tick;
        checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL b2b_ack_a got %b exp 1", ack0); end
        checks++; if (rdata0 !== 32'd35) begin errors++; $display("FAIL b2b_wr_rdata got %0d exp 35", rdata0); end
        we0 = 1'b0;
        tick;
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b exp 0", ack0); end
        tick;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd3) begin errors++; $display("FAIL b2b_rd got en=%b we=%b addr=%0d exp 1/0/3", mem_en, mem_we, mem_addr); end
        tick; tick;
        checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL b2b_ack_b got %b exp 1", ack0); end
        checks++; if (rdata0 !== 32'd2) begin errors++; $display("FAIL b2b_rdata got %0d exp 2", rdata0); end
        req0 = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'd0; wdata1 = 32'd76;
        tick;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL rm_issue got en=%b we=%b exp 1/1", mem_en, mem_we); end
        #2 rst = 1'b1;
        req1 = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_async got en=%b busy=%b exp 0/0", mem_en, busy); end
        tick;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++; if (ack1 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_quiet[%0d] got ack1=%b busy=%b exp 0/0", i, ack1, busy); end
        end
        checks++; if (mem[0] !== 32'd0) begin errors++; $display("FAIL rm_mem0 got %0d exp 0", mem[0]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bd_we = 1'b0; bd_addr = 5'd0; bd_data = 32'd0;
        test_reset;
        test_read;
        test_contention;
        test_round_robin;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
